// File: rtl/key_debouncer.sv
// Per-key synchroniser, debounce FSM and registered press/release pulse generator.
// Define KEY_AUTO_REPEAT_EN to add auto-repeat of key_press on keys selected by REPEAT_MASK.
module key_debouncer #(
    parameter int unsigned          KEY_COUNT       = 4,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter int unsigned          DEBOUNCE_CYCLES = 8,
    parameter int unsigned          REPEAT_DELAY    = 50,
    parameter int unsigned          REPEAT_PERIOD   = 10,
    parameter logic [KEY_COUNT-1:0] REPEAT_MASK     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_COUNT-1:0] keyN_in,
    output logic [KEY_COUNT-1:0] key_level,
    output logic [KEY_COUNT-1:0] key_press,
    output logic [KEY_COUNT-1:0] key_release
);

    localparam int unsigned          CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]      CntMax = CntW'(DEBOUNCE_CYCLES);

`ifdef KEY_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);
`endif

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1
        || $bits(REPEAT_MASK) != KEY_COUNT) begin : g_bad_params
        $error("key_debouncer: illegal parameter value");
    end

    for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q;
        state_e                 state_q;
        logic [CntW-1:0]        cnt_q;
        logic                   level_q;
        logic                   press_q;
        logic                   release_q;
        logic                   s;
        logic                   rpt_fire;

        // Flops reset to 1 so a key held through reset is seen as a fresh press.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], keyN_in[k]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= StReleased;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    StReleased: begin
                        if (!s) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q <= StPressed;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                            end else begin
                                state_q <= StPressWait;
                                cnt_q   <= CntW'(1);
                            end
                        end
                    end
                    StPressWait: begin
                        if (s) begin
                            state_q <= StReleased;
                            cnt_q   <= '0;
                        end else if (cnt_q + CntW'(1) == CntMax) begin
                            state_q <= StPressed;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StPressed: begin
                        if (s) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q   <= StReleased;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                            end else begin
                                state_q <= StReleaseWait;
                                cnt_q   <= CntW'(1);
                            end
                        end else begin
                            press_q <= rpt_fire;
                        end
                    end
                    StReleaseWait: begin
                        if (!s) begin
                            state_q <= StPressed;
                            cnt_q   <= '0;
                        end else if (cnt_q + CntW'(1) == CntMax) begin
                            state_q   <= StReleased;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    default: state_q <= StReleased;
                endcase
            end
        end

`ifdef KEY_AUTO_REPEAT_EN
        if (REPEAT_MASK[k]) begin : g_rpt
            logic [RptW-1:0] rpt_q;
            logic            rpt_started_q;
            logic [RptW-1:0] rpt_target;

            assign rpt_target = rpt_started_q ? RptW'(REPEAT_PERIOD) : RptW'(REPEAT_DELAY);
            assign rpt_fire   = (state_q == StPressed) && !s && (rpt_q + RptW'(1) == rpt_target);

            // Held at zero outside the pressed states; frozen while a release is being judged.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rpt_q         <= '0;
                    rpt_started_q <= 1'b0;
                end else if (state_q == StReleased || state_q == StPressWait) begin
                    rpt_q         <= '0;
                    rpt_started_q <= 1'b0;
                end else if (state_q == StPressed && !s) begin
                    if (rpt_fire) begin
                        rpt_q         <= '0;
                        rpt_started_q <= 1'b1;
                    end else begin
                        rpt_q <= rpt_q + RptW'(1);
                    end
                end
            end
        end else begin : g_no_rpt
            assign rpt_fire = 1'b0;
        end
`else
        assign rpt_fire = 1'b0;
`endif

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
    end

endmodule
